// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl_fifo: small circular FIFO for {addr, data} pixel entries, with a flush.
// Latency: a pushed entry is visible at rdat_o one cycle after the push edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports: clk_i/rst_i (sync, active-high), flush_i empties the FIFO, push_i/wdat_i write,
//        pop_i/rdat_o read the head, empty_o/full_o report occupancy.
module sram_write_ctrl_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdat_i,
    output logic [WIDTH-1:0] rdat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign rdat_o  = mem_q[rd_ptr_q];

    // When full, the slot being written is the one being popped; the pop
    // reads the old value combinationally before the edge overwrites it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdat_i;
    end
endmodule

// sram_write_ctrl: turns SPI pixel/window/clear requests into SRAM writes and shares the port with display reads.
// Latency: 1 cycle from sampled request to o_mem_*; a pixel on an empty FIFO reaches o_mem_* 2 cycles after its pulse.
// Backpressure: reads always win the port; pixels wait in the FIFO and are dropped (sticky o_overflow) when it is full.
//
// Ports: i_clk/i_rst (sync, active-high); i_pixel_data + i_sram_write_req push one pixel at the cursor;
//        i_col_addr={XS,XE}, i_row_addr={YS,YE} with i_sram_waddr_set_req reloading the cursor;
//        i_sram_clr_req starts a full-frame zero sweep; i_rd_req/i_rd_addr display reads (o_rd_grant);
//        o_mem_en/we/addr/wdata drive the SRAM; o_busy during the sweep; o_overflow sticky pixel-drop flag.
module sram_write_ctrl #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_pixel_data,
    input  logic [31:0]       i_col_addr,
    input  logic [31:0]       i_row_addr,
    input  logic              i_sram_clr_req,
    input  logic              i_sram_write_req,
    input  logic              i_sram_waddr_set_req,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_grant,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_overflow
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_e;

    localparam logic [31:0]       H_LIM     = 32'(H_RES);
    localparam logic [31:0]       V_LIM     = 32'(V_RES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam int                FW        = ADDR_W + 16;

    state_e            state_q, state_d;
    logic [15:0]       x_q, x_d;
    logic [15:0]       y_q, y_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              rd_grant_q, rd_grant_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic [15:0]       xs, xe, ys, ye;
    logic [15:0]       tgt_x, tgt_y;
    logic              in_frame;
    logic [31:0]       lin_addr;
    logic              push;
    logic              pop;
    logic [FW-1:0]     fifo_wdat;
    logic [FW-1:0]     fifo_rdat;
    logic              fifo_empty;
    logic              fifo_full;

    assign xs = i_col_addr[31:16];
    assign xe = i_col_addr[15:0];
    assign ys = i_row_addr[31:16];
    assign ye = i_row_addr[15:0];

    sram_write_ctrl_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .flush_i (i_sram_clr_req),
        .push_i  (push),
        .pop_i   (pop),
        .wdat_i  (fifo_wdat),
        .rdat_o  (fifo_rdat),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Pixel targeting, clipping and cursor advance.
    always_comb begin
        // A set pulse coinciding with a write redirects that pixel to XS,YS.
        tgt_x     = i_sram_waddr_set_req ? xs : x_q;
        tgt_y     = i_sram_waddr_set_req ? ys : y_q;
        in_frame  = ({16'd0, tgt_x} < H_LIM) && ({16'd0, tgt_y} < V_LIM);
        lin_addr  = {16'd0, tgt_y} * H_LIM + {16'd0, tgt_x};
        fifo_wdat = {lin_addr[ADDR_W-1:0], i_pixel_data};
        // A clear flushes the FIFO this cycle, so a simultaneous pixel is lost.
        push      = i_sram_write_req && in_frame && !i_sram_clr_req;

        x_d = x_q;
        y_d = y_q;
        if (i_sram_waddr_set_req) begin
            x_d = xs;
            y_d = ys;
        end
        if (i_sram_write_req) begin
            if (tgt_x == xe) begin
                x_d = xs;
                y_d = (tgt_y == ye) ? ys : tgt_y + 16'd1;
            end else begin
                x_d = tgt_x + 16'd1;
                y_d = tgt_y;
            end
        end
        if (i_sram_clr_req) begin
            x_d = '0;
            y_d = '0;
        end
    end

    // Port arbitration: read > clear sweep > FIFO pop > idle.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        rd_grant_d  = 1'b0;
        pop         = 1'b0;

        if (i_rd_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = i_rd_addr;
            rd_grant_d = 1'b1;
        end else if (state_q == S_CLEAR && !i_sram_clr_req) begin
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b1;
            mem_addr_d = clr_cnt_q;
            clr_cnt_d  = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) state_d = S_IDLE;
        end else if (state_q == S_IDLE && !fifo_empty && !i_sram_clr_req) begin
            pop         = 1'b1;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_rdat[FW-1:16];
            mem_wdata_d = fifo_rdat[15:0];
        end

        if (i_sram_clr_req) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
        end

        // Registered from the next state so busy falls with the final sweep write.
        busy_d = (state_d == S_CLEAR);
        ovf_d  = ovf_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            clr_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_grant_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            clr_cnt_q   <= clr_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_grant_q  <= rd_grant_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign o_rd_grant  = rd_grant_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_busy      = busy_q;
    assign o_overflow  = ovf_q;
endmodule

// File: tb/tb_sram_write_ctrl.sv
// tb_sram_write_ctrl: randomized checks of sram_write_ctrl against a cursor/queue reference model.
// Frame is 320x8 so full clear sweeps stay short; address stride matches the default width.
// Inputs change 2 time units after the rising edge; outputs are logged on the falling edge.
module tb_sram_write_ctrl;
    localparam int H     = 320;
    localparam int V     = 8;
    localparam int AW    = 17;
    localparam int FRAME = H * V;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [15:0]   i_pixel_data = '0;
    logic [31:0]   i_col_addr = '0;
    logic [31:0]   i_row_addr = '0;
    logic          i_sram_clr_req = 1'b0;
    logic          i_sram_write_req = 1'b0;
    logic          i_sram_waddr_set_req = 1'b0;
    logic          i_rd_req = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_rd_grant, o_mem_en, o_mem_we, o_busy, o_overflow;
    logic [AW-1:0] o_mem_addr;
    logic [15:0]   o_mem_wdata;

    always #5 i_clk = ~i_clk;

    sram_write_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pixel_data(i_pixel_data),
        .i_col_addr(i_col_addr), .i_row_addr(i_row_addr),
        .i_sram_clr_req(i_sram_clr_req), .i_sram_write_req(i_sram_write_req),
        .i_sram_waddr_set_req(i_sram_waddr_set_req),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_grant(o_rd_grant),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
        logic        grant;
        logic        busy;
        int          cyc;
    } txn_t;

    txn_t mon_q[$];
    txn_t mon_t;
    int   cyc = 0;
    int   busy_cycles = 0;
    int   tests_run = 0;
    int   fails = 0;

    // Reference model state: cursor, window, expected writes and reads.
    int          m_x = 0, m_y = 0;
    int          w_xs = 0, w_xe = 0, w_ys = 0, w_ye = 0;
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    int          exp_rd[$];
    bit          last_rd = 0;

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (o_mem_en === 1'b1) begin
            mon_t.we    = o_mem_we;
            mon_t.addr  = {15'd0, o_mem_addr};
            mon_t.data  = o_mem_wdata;
            mon_t.grant = o_rd_grant;
            mon_t.busy  = o_busy;
            mon_t.cyc   = cyc;
            mon_q.push_back(mon_t);
        end
        if (o_busy === 1'b1) busy_cycles++;
    end

    function automatic void model_pixel(input bit set, input logic [15:0] d);
        if (set) begin
            m_x = w_xs;
            m_y = w_ys;
        end
        if (m_x < H && m_y < V) begin
            exp_addr.push_back((m_y * H + m_x) % (1 << AW));
            exp_data.push_back(d);
        end
        if (m_x == w_xe) begin
            m_x = w_xs;
            m_y = (m_y == w_ye) ? w_ys : (m_y + 1) % 65536;
        end else begin
            m_x = (m_x + 1) % 65536;
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_window(input int xs, input int xe, input int ys, input int ye);
        w_xs = xs; w_xe = xe; w_ys = ys; w_ye = ye;
        i_col_addr = {16'(xs), 16'(xe)};
        i_row_addr = {16'(ys), 16'(ye)};
    endtask

    task automatic pixel(input bit set, input logic [15:0] d);
        i_sram_write_req     = 1'b1;
        i_sram_waddr_set_req = set;
        i_pixel_data         = d;
        model_pixel(set, d);
        tick();
        i_sram_write_req     = 1'b0;
        i_sram_waddr_set_req = 1'b0;
    endtask

    task automatic drive_rd(input bit rd);
        int a;
        a         = $urandom_range(0, FRAME - 1);
        i_rd_req  = rd;
        i_rd_addr = AW'(a);
        if (rd) exp_rd.push_back(a);
        last_rd = rd;
    endtask

    task automatic pulse_clr();
        i_sram_clr_req = 1'b1;
        tick();
        i_sram_clr_req = 1'b0;
    endtask

    task automatic clear_logs();
        mon_q.delete();
        exp_addr.delete();
        exp_data.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({o_mem_en, o_mem_we, o_rd_grant, o_busy, o_overflow} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags got=%b want=00000", {o_mem_en, o_mem_we, o_rd_grant, o_busy, o_overflow});
        end
        tests_run++;
        if (o_mem_addr !== '0 || o_mem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_bus addr=%0h data=%0h want 0/0", o_mem_addr, o_mem_wdata);
        end
        i_rst = 1'b0;
        m_x = 0;
        m_y = 0;
        tick();
    endtask

    task automatic test_window();
        int exp_c[5];
        logic [15:0] d[5];
        int c0, wi, bad;
        exp_c = '{1602, 1603, 1922, 1923, 1602};
        clear_logs();
        set_window(2, 3, 5, 6);
        i_sram_waddr_set_req = 1'b1;
        tick();
        i_sram_waddr_set_req = 1'b0;
        m_x = 2;
        m_y = 5;
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            d[k] = 16'($urandom);
            pixel(1'b0, d[k]);
        end
        repeat (6) tick();
        tests_run++;
        if (mon_q.size() !== 5) begin
            fails++;
            $display("FAIL window_count got=%0d want=5", mon_q.size());
        end
        wi = 0; bad = 0;
        foreach (mon_q[k]) begin
            if (wi >= 5 || mon_q[k].we !== 1'b1 || mon_q[k].addr !== exp_c[wi] || mon_q[k].data !== d[wi]) bad++;
            wi++;
        end
        tests_run++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL window_addr_data bad_entries=%0d want=0", bad);
        end
        tests_run++;
        if (mon_q.size() > 0 && mon_q[0].cyc - c0 !== 2) begin
            fails++;
            $display("FAIL pixel_latency got=%0d want=2", mon_q[0].cyc - c0);
        end
    endtask

    task automatic test_random();
        int n, xs, ys, wi, bad, ri, rbad;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            xs = $urandom_range(0, 318);
            ys = $urandom_range(0, 6);
            set_window(xs, xs + $urandom_range(0, 3), ys, ys + $urandom_range(0, 1));
            n = $urandom_range(3, 10);
            for (int p = 0; p < n; p++) begin
                drive_rd(!last_rd && ($urandom_range(0, 2) == 0));
                pixel(p == 0, 16'($urandom));
                drive_rd(!last_rd && ($urandom_range(0, 2) == 0));
                tick();
            end
            drive_rd(1'b0);
            repeat (8) tick();
            wi = 0; bad = 0; ri = 0; rbad = 0;
            foreach (mon_q[k]) begin
                if (mon_q[k].we === 1'b1) begin
                    if (wi >= exp_addr.size() || mon_q[k].grant !== 1'b0 ||
                        mon_q[k].addr !== exp_addr[wi] || mon_q[k].data !== exp_data[wi]) bad++;
                    wi++;
                end else begin
                    if (ri >= exp_rd.size() || mon_q[k].grant !== 1'b1 || mon_q[k].addr !== exp_rd[ri]) rbad++;
                    ri++;
                end
            end
            tests_run++;
            if (wi !== exp_addr.size() || bad !== 0) begin
                fails++;
                $display("FAIL random_writes iter=%0d got=%0d bad=%0d want=%0d bad=0", it, wi, bad, exp_addr.size());
            end
            tests_run++;
            if (ri !== exp_rd.size() || rbad !== 0) begin
                fails++;
                $display("FAIL random_reads iter=%0d got=%0d bad=%0d want=%0d bad=0", it, ri, rbad, exp_rd.size());
            end
        end
        tests_run++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL random_overflow got=%b want=0", o_overflow);
        end
    endtask

    task automatic test_read_priority();
        int bad;
        clear_logs();
        set_window(0, H - 1, 0, V - 1);
        for (int k = 0; k < 6; k++) begin
            drive_rd(1'b1);
            if (k < 4) pixel(k == 0, 16'($urandom));
            else tick();
        end
        drive_rd(1'b0);
        repeat (8) tick();
        tests_run++;
        if (mon_q.size() !== 10) begin
            fails++;
            $display("FAIL rdprio_count got=%0d want=10", mon_q.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 6; k++)
                if (mon_q[k].we !== 1'b0 || mon_q[k].grant !== 1'b1 || mon_q[k].addr !== exp_rd[k]) bad++;
            for (int k = 0; k < 4; k++)
                if (mon_q[6+k].we !== 1'b1 || mon_q[6+k].grant !== 1'b0 ||
                    mon_q[6+k].addr !== exp_addr[k] || mon_q[6+k].data !== exp_data[k]) bad++;
            tests_run++;
            if (bad !== 0) begin
                fails++;
                $display("FAIL rdprio_order bad_entries=%0d want=0", bad);
            end
            tests_run++;
            if (mon_q[9].cyc - mon_q[5].cyc !== 4) begin
                fails++;
                $display("FAIL rdprio_back_to_back span=%0d want=4", mon_q[9].cyc - mon_q[5].cyc);
            end
        end
        tests_run++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL rdprio_overflow got=%b want=0", o_overflow);
        end
    endtask

    task automatic test_overflow();
        int wi, bad;
        clear_logs();
        set_window(0, H - 1, 0, V - 1);
        for (int k = 0; k < 8; k++) begin
            drive_rd(1'b1);
            if (k < 6) pixel(k == 0, 16'($urandom));
            else tick();
        end
        // Only the first four pixels fit; the model cursor still advanced for all six.
        exp_addr = exp_addr[0:3];
        exp_data = exp_data[0:3];
        tests_run++;
        if (o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set got=%b want=1", o_overflow);
        end
        drive_rd(1'b0);
        repeat (10) tick();
        wi = 0; bad = 0;
        foreach (mon_q[k]) begin
            if (mon_q[k].we === 1'b1) begin
                if (wi >= 4 || mon_q[k].addr !== exp_addr[wi] || mon_q[k].data !== exp_data[wi]) bad++;
                wi++;
            end
        end
        tests_run++;
        if (wi !== 4 || bad !== 0) begin
            fails++;
            $display("FAIL overflow_writes got=%0d bad=%0d want=4 bad=0", wi, bad);
        end
        tests_run++;
        if (o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky got=%b want=1", o_overflow);
        end
        // Queue two pixels behind reads, then reset: they must never be written.
        drive_rd(1'b1);
        pixel(1'b1, 16'hAAAA);
        pixel(1'b0, 16'h5555);
        i_rst = 1'b1;
        drive_rd(1'b0);
        tick();
        i_rst = 1'b0;
        m_x = 0;
        m_y = 0;
        mon_q.delete();
        repeat (6) tick();
        tests_run++;
        if (o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_reset got=%b want=0", o_overflow);
        end
        tests_run++;
        if (mon_q.size() !== 0) begin
            fails++;
            $display("FAIL reset_abandons_fifo writes=%0d want=0", mon_q.size());
        end
    endtask

    task automatic test_clear(input bit with_reads);
        int n, wi, bad, ri;
        bit rd;
        clear_logs();
        busy_cycles = 0;
        pulse_clr();
        n  = 0;
        rd = 1'b1;
        while (o_busy === 1'b1 && n < 4 * FRAME) begin
            drive_rd(with_reads ? rd : 1'b0);
            rd = !rd;
            tick();
            n++;
        end
        drive_rd(1'b0);
        tick();
        tests_run++;
        if (n >= 4 * FRAME) begin
            fails++;
            $display("FAIL clear_timeout reads=%0d busy still high after %0d cycles", with_reads, n);
        end
        tests_run++;
        if (busy_cycles !== (with_reads ? 2 * FRAME : FRAME)) begin
            fails++;
            $display("FAIL clear_busy_cycles reads=%0d got=%0d want=%0d", with_reads, busy_cycles,
                     with_reads ? 2 * FRAME : FRAME);
        end
        wi = 0; bad = 0; ri = 0;
        foreach (mon_q[k]) begin
            if (mon_q[k].we === 1'b1) begin
                if (mon_q[k].addr !== wi || mon_q[k].data !== 16'd0 || mon_q[k].busy !== (wi != FRAME - 1)) bad++;
                wi++;
            end else begin
                ri++;
            end
        end
        tests_run++;
        if (wi !== FRAME || bad !== 0) begin
            fails++;
            $display("FAIL clear_sweep reads=%0d writes=%0d bad=%0d want=%0d bad=0", with_reads, wi, bad, FRAME);
        end
        tests_run++;
        if (ri !== exp_rd.size()) begin
            fails++;
            $display("FAIL clear_reads_served got=%0d want=%0d", ri, exp_rd.size());
        end
        // Cursor returned to 0,0 by the clear.
        clear_logs();
        m_x = 0;
        m_y = 0;
        pixel(1'b0, 16'h1234);
        repeat (4) tick();
        tests_run++;
        if (mon_q.size() !== 1 || mon_q[0].addr !== 0 || mon_q[0].data !== 16'h1234) begin
            fails++;
            $display("FAIL clear_cursor_home writes=%0d addr=%0d want 1 write at 0", mon_q.size(),
                     mon_q.size() > 0 ? mon_q[0].addr : -1);
        end
    endtask

    task automatic test_restart();
        int n, wi, bad;
        clear_logs();
        pulse_clr();
        repeat (100) tick();
        pulse_clr();
        repeat (5) tick();
        set_window(10, 12, 1, 2);
        pixel(1'b1, 16'($urandom));
        pixel(1'b0, 16'($urandom));
        pixel(1'b0, 16'($urandom));
        n = 0;
        while (o_busy === 1'b1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        repeat (6) tick();
        tests_run++;
        if (n >= 2 * FRAME) begin
            fails++;
            $display("FAIL restart_timeout busy high after %0d cycles", n);
        end
        wi = 0; bad = 0;
        foreach (mon_q[k]) begin
            if (wi < 100) begin
                if (mon_q[k].addr !== wi || mon_q[k].data !== 16'd0) bad++;
            end else if (wi < 100 + FRAME) begin
                if (mon_q[k].addr !== wi - 100 || mon_q[k].data !== 16'd0) bad++;
            end else if (wi < 103 + FRAME) begin
                if (mon_q[k].addr !== exp_addr[wi-100-FRAME] || mon_q[k].data !== exp_data[wi-100-FRAME] ||
                    mon_q[k].busy !== 1'b0) bad++;
            end
            wi++;
        end
        tests_run++;
        if (wi !== 103 + FRAME || bad !== 0) begin
            fails++;
            $display("FAIL restart_sequence writes=%0d bad=%0d want=%0d bad=0", wi, bad, 103 + FRAME);
        end
        tests_run++;
        if (exp_addr.size() !== 3 || exp_addr[0] !== 330 || exp_addr[2] !== 332) begin
            fails++;
            $display("FAIL restart_model_addrs size=%0d", exp_addr.size());
        end
    endtask

    task automatic test_clip();
        int wi, bad;
        clear_logs();
        set_window(400, 401, 0, 0);
        pixel(1'b1, 16'h0001);
        pixel(1'b0, 16'h0002);
        pixel(1'b0, 16'h0003);
        repeat (4) tick();
        tests_run++;
        if (mon_q.size() !== 0) begin
            fails++;
            $display("FAIL clip_x400 writes=%0d want=0", mon_q.size());
        end
        // Frame corner: x=320 and y=8 are off-frame, 319/7 is the last pixel.
        clear_logs();
        set_window(319, 320, 7, 8);
        for (int k = 0; k < 5; k++) pixel(k == 0, 16'($urandom));
        repeat (5) tick();
        wi = 0; bad = 0;
        foreach (mon_q[k]) begin
            if (wi >= exp_addr.size() || mon_q[k].addr !== exp_addr[wi] || mon_q[k].data !== exp_data[wi]) bad++;
            wi++;
        end
        tests_run++;
        if (wi !== 2 || exp_addr.size() !== 2 || bad !== 0) begin
            fails++;
            $display("FAIL clip_corner writes=%0d bad=%0d want=2 bad=0", wi, bad);
        end
    endtask

    task automatic test_reset_mid_sweep();
        clear_logs();
        pulse_clr();
        repeat (50) tick();
        i_rst = 1'b1;
        tick();
        tests_run++;
        if ({o_mem_en, o_mem_we, o_rd_grant, o_busy, o_overflow} !== 5'b0 || o_mem_addr !== '0 ||
            o_mem_wdata !== '0) begin
            fails++;
            $display("FAIL rst_mid_sweep flags=%b addr=%0h data=%0h want all 0",
                     {o_mem_en, o_mem_we, o_rd_grant, o_busy, o_overflow}, o_mem_addr, o_mem_wdata);
        end
        i_rst = 1'b0;
        m_x = 0;
        m_y = 0;
        mon_q.delete();
        repeat (3) tick();
        pixel(1'b0, 16'hBEEF);
        repeat (4) tick();
        tests_run++;
        if (mon_q.size() !== 1 || mon_q[0].addr !== 0 || mon_q[0].data !== 16'hBEEF || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_then_idle writes=%0d busy=%b want 1 write at 0, busy 0", mon_q.size(), o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_window();
        test_random();
        test_read_priority();
        test_overflow();
        test_clear(1'b0);
        test_clear(1'b1);
        test_restart();
        test_clip();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/sram_write_ctrl.md
Name: sram_write_ctrl

Overview:
Sequences the single-port pixel SRAM behind the SPI command decoder. It turns pixel-write, window-set and clear requests from the decoder into addressed SRAM writes, using a window cursor and a small pixel FIFO. It runs a full-frame clear sweep, and arbitrates the one SRAM port between the display read path and the SPI write path. It sits between the SPI instruction decoder and the frame-buffer SRAM.

Parameters:
H_RES, 320, frame width in pixels; stride of the linear address.
V_RES, 240, frame height in pixels.
ADDR_W, 17, SRAM address width; must satisfy H_RES*V_RES <= 2^ADDR_W.
FIFO_DEPTH, 4, pixel FIFO entries; must be a power of 2, at least 2.

Ports:
i_clk  in  1  system clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_pixel_data  in  16  RGB565 pixel, valid with i_sram_write_req
i_col_addr  in  32  XS[31:16], XE[15:0]
i_row_addr  in  32  YS[31:16], YE[15:0]
i_sram_clr_req  in  1  1-cycle pulse: clear the whole frame
i_sram_write_req  in  1  1-cycle pulse: write one pixel at the cursor
i_sram_waddr_set_req  in  1  1-cycle pulse: reload the cursor from the window
i_rd_req  in  1  display read request, level
i_rd_addr  in  ADDR_W  display read address
o_rd_grant  out  1  read issued this cycle; aligned with o_mem_*
o_mem_en  out  1  SRAM enable
o_mem_we  out  1  SRAM write enable
o_mem_addr  out  ADDR_W  SRAM address
o_mem_wdata  out  16  SRAM write data
o_busy  out  1  clear sweep in progress
o_overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full

Behaviour:
- Reset (i_rst=1 at an edge): all outputs 0; cursor x=0, y=0; FIFO empty; FSM in IDLE. Reset mid-sweep or mid-FIFO abandons all pending work.
- Cursor registers x, y are 16 bits wide.
  - On i_sram_waddr_set_req: x<=XS, y<=YS.
- On i_sram_write_req, the pixel is targeted at the current cursor (or at XS,YS if a set request arrives in the same cycle; set takes priority). Then the cursor advances:
  - if x==XE: x<=XS, and y<=(y==YE ? YS : y+1);
  - else x<=x+1.
- Clipping: a pixel with x>=H_RES or y>=V_RES is not pushed, but the cursor still advances.
- Linear address = y*H_RES + x, truncated to ADDR_W bits. It is computed at push time and stored with the data; each FIFO entry is {addr, data}.
- FIFO behaviour:
  - A push when full is dropped and sets o_overflow; only i_rst clears o_overflow.
  - A push and a pop in the same cycle are legal at any occupancy, including full.
- FSM states:
  - IDLE: accepts pushes and pops the FIFO.
  - CLEAR: entered on i_sram_clr_req from any state.
    - On entry: FIFO flushed, cursor set to 0,0, clear counter set to 0, o_busy=1.
    - Pushes during CLEAR are accepted into the FIFO but not popped until the sweep ends.
    - Each granted sweep cycle writes 0 at the counter address and increments the counter.
    - After the write at H_RES*V_RES-1, go to IDLE; o_busy drops in the same cycle that write appears on o_mem_*.
    - An i_sram_clr_req during CLEAR restarts the counter at 0.
- Port arbitration, decided per cycle, priority order:
  1. i_rd_req
  2. the clear sweep (CLEAR only)
  3. a FIFO pop (IDLE only, FIFO non-empty)
  4. idle: o_mem_en=0
- Outputs are registered: a request sampled at edge N appears on o_mem_* / o_rd_grant after edge N, so one cycle of latency.
  - Read: en=1, we=0, addr=i_rd_addr, o_rd_grant=1.
  - Write: en=1, we=1, o_rd_grant=0.
  - A continuous i_rd_req starves writes. The display path must leave gaps of at least 1 free cycle in 4.
- Minimum pixel path latency, empty FIFO, no read pending: pixel appears on o_mem_* 2 cycles after i_sram_write_req (1 cycle FIFO write, 1 cycle output register).
- Width rules:
  - Clear counter is ADDR_W bits.
  - FIFO count is log2(FIFO_DEPTH)+1 bits.
  - XS/XE/YS/YE use the full 16 bits; XS>XE or YS>YE is not guarded, and the cursor simply follows the rules above.

Test Plan:
- Reset, then window XS=2,XE=3,YS=5,YE=6, set pulse, 5 write pulses, no reads -> writes at addresses 1602, 1603, 1922, 1923, then wrap to 1602, with the data in pulse order.
- i_rd_req held high for 6 cycles while 4 pixels are queued -> 6 reads with o_rd_grant=1 in those cycles; the 4 writes follow back-to-back after reads stop; o_overflow=0.
- 6 write pulses on consecutive cycles while i_rd_req is held high (FIFO_DEPTH=4) -> 4 writes later emerge; o_overflow=1 and stays 1 until i_rst.
- i_sram_clr_req, no reads -> o_busy=1 for 76800 cycles, writes of 0 at 0..76799 in order, then o_busy=0; with a read every other cycle the sweep takes 153600 cycles.
- Second clr pulse at counter=100, plus pixels pushed during the sweep -> sweep restarts at 0; queued pixels are written only after o_busy falls.
- Cursor at x=400 (XS=400) with a write pulse -> no SRAM write, x advances; assert i_rst mid-sweep -> next cycle all outputs 0 and the FSM is in IDLE.
